// File: rtl/oscilo_ui_pkg.sv
// Shared types and constants for the oscilloscope UI state-entry block.
package oscilo_ui_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } step_state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } step_dir_e;

    // nibble_sel encoding
    localparam logic NIBBLE_LO = 1'b0;  // edit state[3:0]
    localparam logic NIBBLE_HI = 1'b1;  // edit state[7:4]

    // Increment or decrement one nibble modulo 16, leaving the other untouched.
    function automatic logic [7:0] step_nibble(
        input logic [7:0] value,
        input logic       sel,
        input step_dir_e  dir
    );
        logic [3:0] nib;
        logic [7:0] res;
        nib = (sel == NIBBLE_HI) ? value[7:4] : value[3:0];
        nib = (dir == DIR_UP) ? nib + 4'd1 : nib - 4'd1;
        res = value;
        if (sel == NIBBLE_HI) begin
            res[7:4] = nib;
        end else begin
            res[3:0] = nib;
        end
        return res;
    endfunction

endpackage

// File: rtl/state_input_debouncer.sv
// Two-flop synchronizer plus consecutive-sample debouncer for one button.
// The reported level is qualified by an "armed" flag: after reset a stable
// released level must be debounced before a press is ever reported, so a
// button held through reset never looks like a fresh press.
module debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level
);
    import oscilo_ui_pkg::*;

    localparam int unsigned   CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] arm_cnt_q, arm_cnt_d;
    logic          level_q, level_d;
    logic          armed_q, armed_d;

    // Synchronize, count consecutive disagreeing samples, and arm on a debounced low.
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        cnt_d     = '0;
        arm_cnt_d = '0;
        level_d   = level_q;
        armed_d   = armed_q;

        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                if (!sync2_q) begin
                    armed_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (!armed_q && !sync2_q && !level_q) begin
            if (arm_cnt_q == CNT_LAST) begin
                armed_d = 1'b1;
            end else begin
                arm_cnt_d = arm_cnt_q + CW'(1);
            end
        end
    end

    // Debouncer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            arm_cnt_q <= '0;
            level_q   <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            arm_cnt_q <= arm_cnt_d;
            level_q   <= level_d;
            armed_q   <= armed_d;
        end
    end

    assign level = level_q & armed_q;

endmodule

// File: rtl/state_input.sv
// Button-driven editor for an 8-bit state value: up/down step the selected
// nibble with hold-to-repeat, sel toggles which nibble is edited.
module state_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sel,
    output logic [7:0] state,
    output logic       state_change,
    output logic       nibble_sel
);
    import oscilo_ui_pkg::*;

    localparam int unsigned   TMAX      = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned   TW        = $clog2(TMAX + 1);
    localparam logic [TW-1:0] LOAD_HOLD = TW'(REPEAT_DELAY);
    localparam logic [TW-1:0] LOAD_RATE = TW'(REPEAT_RATE);

    logic up_lvl, dn_lvl, sel_lvl;
    logic up_prev_q, up_prev_d;
    logic dn_prev_q, dn_prev_d;
    logic sel_prev_q, sel_prev_d;
    logic up_rise, dn_rise, sel_rise;

    step_state_e fsm_q, fsm_d;
    step_dir_e   dir_q, dir_d;
    step_dir_e   step_dir;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    state_q, state_d;
    logic          state_change_q, state_change_d;
    logic          nibble_sel_q, nibble_sel_d;
    logic          do_step, latched_lvl, other_lvl;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_up), .level(up_lvl)
    );
    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_down), .level(dn_lvl)
    );
    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_sel), .level(sel_lvl)
    );

    assign up_rise  = up_lvl  & ~up_prev_q;
    assign dn_rise  = dn_lvl  & ~dn_prev_q;
    assign sel_rise = sel_lvl & ~sel_prev_q;

    // Step FSM next-state, timer, nibble select and state update.
    always_comb begin
        up_prev_d      = up_lvl;
        dn_prev_d      = dn_lvl;
        sel_prev_d     = sel_lvl;
        fsm_d          = fsm_q;
        dir_d          = dir_q;
        step_dir       = dir_q;
        timer_d        = (timer_q != '0) ? timer_q - TW'(1) : '0;
        do_step        = 1'b0;
        latched_lvl    = (dir_q == DIR_UP) ? up_lvl : dn_lvl;
        other_lvl      = (dir_q == DIR_UP) ? dn_lvl : up_lvl;
        nibble_sel_d   = sel_rise ? ~nibble_sel_q : nibble_sel_q;

        case (fsm_q)
            ST_IDLE: begin
                if (up_rise ^ dn_rise) begin
                    do_step  = 1'b1;
                    step_dir = up_rise ? DIR_UP : DIR_DOWN;
                    dir_d    = step_dir;
                    fsm_d    = ST_HOLD;
                    timer_d  = LOAD_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!latched_lvl || other_lvl) begin
                    fsm_d   = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q <= TW'(1)) begin
                    do_step = 1'b1;
                    fsm_d   = ST_REPEAT;
                    timer_d = LOAD_RATE;
                end
            end
            default: begin
                fsm_d   = ST_IDLE;
                timer_d = '0;
            end
        endcase

        // Step uses the pre-toggle nibble_sel_q, so a coincident sel toggle
        // only affects later steps.
        state_d        = do_step ? step_nibble(state_q, nibble_sel_q, step_dir) : state_q;
        state_change_d = do_step;
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_prev_q      <= 1'b0;
            dn_prev_q      <= 1'b0;
            sel_prev_q     <= 1'b0;
            fsm_q          <= ST_IDLE;
            dir_q          <= DIR_UP;
            timer_q        <= '0;
            state_q        <= '0;
            state_change_q <= 1'b0;
            nibble_sel_q   <= NIBBLE_LO;
        end else begin
            up_prev_q      <= up_prev_d;
            dn_prev_q      <= dn_prev_d;
            sel_prev_q     <= sel_prev_d;
            fsm_q          <= fsm_d;
            dir_q          <= dir_d;
            timer_q        <= timer_d;
            state_q        <= state_d;
            state_change_q <= state_change_d;
            nibble_sel_q   <= nibble_sel_d;
        end
    end

    assign state        = state_q;
    assign state_change = state_change_q;
    assign nibble_sel   = nibble_sel_q;

endmodule

// File: tb/tb_state_input.sv
// Self-checking bench for state_input with a cycle-level behavioural model.
module tb_state_input;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RR = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up, btn_down, btn_sel;
    logic [7:0] state;
    logic       state_change, nibble_sel;

    always #5 clk = ~clk;

    state_input #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_sel(btn_sel),
        .state(state),
        .state_change(state_change),
        .nibble_sel(nibble_sel)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: buttons are judged by the length of the current run
    // of identical synchronized samples; the step machine by due cycles.
    bit         m_pipe1[3], m_pipe2[3];
    int         m_run_len[3];
    bit         m_run_val[3];
    bit         m_lvl[3], m_armed[3], m_q[3], m_qprev[3];
    logic [7:0] m_state;
    bit         m_sc, m_nsel;
    int         m_mode, m_dir, m_due;
    int         cyc = 0;
    int         sc_count = 0;
    int         sc_cycles[$];

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            m_pipe1[b] = 0; m_pipe2[b] = 0; m_run_len[b] = 0; m_run_val[b] = 0;
            m_lvl[b] = 0; m_armed[b] = 0; m_q[b] = 0; m_qprev[b] = 0;
        end
        m_state = 8'h00; m_sc = 0; m_nsel = 0; m_mode = 0; m_dir = 0; m_due = 0;
    endtask

    task automatic model_step(input bit r0, input bit r1, input bit r2);
        bit raw[3];
        bit rise[3];
        bit step, use_hi, sample;
        int nib;
        raw[0] = r0; raw[1] = r1; raw[2] = r2;
        for (int b = 0; b < 3; b++) rise[b] = m_q[b] && !m_qprev[b];
        step = 0; m_sc = 0; use_hi = m_nsel;
        if (rise[2]) m_nsel = !m_nsel;
        if (m_mode == 0) begin
            if (rise[0] != rise[1]) begin
                step = 1; m_dir = rise[0] ? 0 : 1; m_mode = 1; m_due = cyc + RD;
            end
        end else begin
            if (!m_q[m_dir] || m_q[1 - m_dir]) m_mode = 0;
            else if (cyc == m_due) begin
                step = 1; m_mode = 2; m_due = cyc + RR;
            end
        end
        if (step) begin
            nib = use_hi ? int'(m_state[7:4]) : int'(m_state[3:0]);
            nib = (nib + (m_dir == 0 ? 1 : 15)) % 16;
            if (use_hi) m_state[7:4] = 4'(nib);
            else        m_state[3:0] = 4'(nib);
            m_sc = 1;
        end
        for (int b = 0; b < 3; b++) begin
            m_qprev[b] = m_q[b];
            sample = m_pipe2[b];
            if (m_run_len[b] > 0 && sample == m_run_val[b]) m_run_len[b]++;
            else begin m_run_val[b] = sample; m_run_len[b] = 1; end
            if (m_run_val[b] != m_lvl[b] && m_run_len[b] >= int'(DB)) begin
                m_lvl[b] = m_run_val[b];
                if (!m_lvl[b]) m_armed[b] = 1;
            end
            if (!m_armed[b] && !m_lvl[b] && !m_run_val[b] && m_run_len[b] >= int'(DB))
                m_armed[b] = 1;
            m_q[b] = m_lvl[b] && m_armed[b];
            m_pipe2[b] = m_pipe1[b];
            m_pipe1[b] = raw[b];
        end
    endtask

    // Advance the model on each rising edge and compare shortly after it.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step(btn_up, btn_down, btn_sel);
            cyc++;
            #2;
            check_eq("state", state, m_state);
            check_eq("state_change", state_change, m_sc);
            check_eq("nibble_sel", nibble_sel, m_nsel);
            if (state_change === 1'b1) begin
                sc_count++;
                sc_cycles.push_back(cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input int b, input int hold);
        if (b == 0) btn_up = 1; else if (b == 1) btn_down = 1; else btn_sel = 1;
        idle(hold);
        if (b == 0) btn_up = 0; else if (b == 1) btn_down = 0; else btn_sel = 0;
        idle(10);
    endtask

    task automatic pulse_reset();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    int base;
    int press_cyc;
    int exp_rel[7] = '{0, 20, 25, 30, 35, 40, 45};

    initial begin
        rst_n = 0; btn_up = 0; btn_down = 0; btn_sel = 0;
        idle(3);
        check_eq("reset_state", state, 8'h00);
        check_eq("reset_sc", state_change, 0);
        check_eq("reset_nsel", nibble_sel, 0);
        rst_n = 1;
        idle(10);

        // Short glitch rejected by the debouncer
        base = sc_count;
        btn_up = 1; idle(3); btn_up = 0; idle(12);
        check_eq("glitch_state", state, 8'h00);
        check_eq("glitch_pulses", sc_count - base, 0);

        // Walk up to 0F, then wrap with exact latency
        for (int i = 0; i < 15; i++) tap(0, 8);
        check_eq("pre_wrap_state", state, 8'h0F);
        base = sc_count;
        btn_up = 1;
        idle(6);
        check_eq("wrap_before_latency", state, 8'h0F);
        idle(1);
        check_eq("wrap_at_latency", state, 8'h00);
        idle(3); btn_up = 0; idle(12);
        check_eq("wrap_pulses", sc_count - base, 1);

        // Select high nibble, step down
        tap(2, 8);
        check_eq("sel_toggled", nibble_sel, 1);
        tap(1, 8);
        check_eq("down_hi_nibble", state, 8'hF0);

        // Auto-repeat timing from a clean reset
        pulse_reset();
        idle(10);
        sc_cycles.delete();
        base = sc_count;
        press_cyc = cyc;
        btn_up = 1; idle(50); btn_up = 0; idle(15);
        check_eq("repeat_pulses", sc_count - base, 7);
        check_eq("repeat_state", state, 8'h07);
        if (sc_cycles.size() == 7) begin
            check_eq("repeat_first_latency", sc_cycles[0] - press_cyc, 7);
            for (int i = 0; i < 7; i++)
                check_eq($sformatf("repeat_rel%0d", i), sc_cycles[i] - sc_cycles[0], exp_rel[i]);
        end

        // Simultaneous press ignored; other button cancels a hold
        base = sc_count;
        btn_up = 1; btn_down = 1; idle(8); btn_up = 0; btn_down = 0; idle(12);
        check_eq("simul_pulses", sc_count - base, 0);
        check_eq("simul_state", state, 8'h07);
        base = sc_count;
        btn_up = 1; idle(10); btn_down = 1; idle(30); btn_up = 0; btn_down = 0; idle(12);
        check_eq("cancel_pulses", sc_count - base, 1);
        check_eq("cancel_state", state, 8'h08);

        // Reset during repeat with the button still held
        btn_up = 1; idle(35);
        rst_n = 0;
        #1;
        check_eq("reset_mid_state", state, 8'h00);
        idle(1); rst_n = 1;
        base = sc_count;
        idle(40);
        check_eq("held_after_reset_pulses", sc_count - base, 0);
        check_eq("held_after_reset_state", state, 8'h00);
        btn_up = 0; idle(12);
        tap(0, 10);
        check_eq("repress_state", state, 8'h01);
        check_eq("repress_pulses", sc_count - base, 1);

        // Random button activity with occasional resets
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) btn_up   = ~btn_up;
            if ($urandom_range(0, 11) == 0) btn_down = ~btn_down;
            if ($urandom_range(0, 15) == 0) btn_sel  = ~btn_sel;
            if ($urandom_range(0, 1499) == 0) pulse_reset();
        end
        btn_up = 0; btn_down = 0; btn_sel = 0;
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
